mul_seq_ctrl: RTL and testbench

Sequencing controller that computes a WIDTH×WIDTH unsigned product by stepping one shared 2-bit×2-bit multiplier cell (`twobit_mul`) across all digit pairs of the operands and accumulating shifted partial products. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It trades area for latency: one multiplier cell and one accumulator replace a full array multiplier.

---
 rtl/mul_seq_pkg.sv | 28 ++
 rtl/half_adder.sv | 12 +
 rtl/twobit_mul.sv | 35 +++
 rtl/mul_seq_ctrl.sv | 104 ++++++++++
 tb/tb_mul_seq_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/mul_seq_pkg.sv
// Shared types and sizing helpers for the digit-serial multiplier controller.
// Helpers let any instance derive its own digit count and counter width.
package mul_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH = 8;

  function automatic int unsigned digits(input int unsigned width);
    return width / 2;
  endfunction

  // Counter must index D*D digit pairs; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    int unsigned n;
    n = (width / 2) * (width / 2);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned D        = digits(DEF_WIDTH);
  localparam int unsigned CNT_W    = cnt_width(DEF_WIDTH);
  localparam int unsigned DONE_CNT = D * D - 1;

endpackage

// File: rtl/half_adder.sv
// Single-bit half adder used inside the 2x2 multiplier cell.
module half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;

endmodule

// File: rtl/twobit_mul.sv
// Combinational 2-bit x 2-bit unsigned multiplier built from two half adders.
module twobit_mul (
  input  logic [1:0] i_a,
  input  logic [1:0] i_b,
  output logic [3:0] o_p
);

  logic w_a0b0;
  logic w_a1b0;
  logic w_a0b1;
  logic w_a1b1;
  logic w_c1;

  assign w_a0b0 = i_a[0] & i_b[0];
  assign w_a1b0 = i_a[1] & i_b[0];
  assign w_a0b1 = i_a[0] & i_b[1];
  assign w_a1b1 = i_a[1] & i_b[1];

  assign o_p[0] = w_a0b0;

  half_adder u_ha_mid (
    .i_a (w_a1b0),
    .i_b (w_a0b1),
    .o_s (o_p[1]),
    .o_c (w_c1)
  );

  half_adder u_ha_top (
    .i_a (w_a1b1),
    .i_b (w_c1),
    .o_s (o_p[2]),
    .o_c (o_p[3])
  );

endmodule

// File: rtl/mul_seq_ctrl.sv
// Area-lean WIDTHxWIDTH unsigned multiplier: one 2x2 cell is stepped across all
// digit pairs, accumulating shifted partial products, with valid/ready on both sides.
module mul_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy
);

  localparam int unsigned L_D     = digits(WIDTH);
  localparam int unsigned L_CNT_W = cnt_width(WIDTH);
  localparam int unsigned PW      = 2 * WIDTH;
  localparam logic [L_CNT_W-1:0] L_DONE_CNT = L_CNT_W'(L_D * L_D - 1);

  state_t               r_state;
  state_t               w_state_next;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [PW-1:0]        r_acc;
  logic [L_CNT_W-1:0]   r_cnt;

  logic [L_CNT_W-1:0]   w_i;
  logic [L_CNT_W-1:0]   w_j;
  logic [1:0]           w_a_dig;
  logic [1:0]           w_b_dig;
  logic [3:0]           w_pp;
  logic [PW-1:0]        w_pp_shift;
  logic                 w_last;

  // i walks the multiplicand digits fastest, j steps once per full sweep of i.
  assign w_i     = L_CNT_W'(32'(r_cnt) % L_D);
  assign w_j     = L_CNT_W'(32'(r_cnt) / L_D);
  assign w_a_dig = r_a[2*w_i +: 2];
  assign w_b_dig = r_b[2*w_j +: 2];
  assign w_last  = (r_cnt == L_DONE_CNT);

  twobit_mul u_cell (
    .i_a (w_a_dig),
    .i_b (w_b_dig),
    .o_p (w_pp)
  );

  assign w_pp_shift = PW'(w_pp) << (2 * (w_i + w_j));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_next = RUN;
      RUN:     if (w_last)    w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default:                w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a   <= a;
            r_b   <= b;
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        RUN: begin
          r_acc <= r_acc + w_pp_shift;
          // Park at zero so digit indices stay in range while DONE holds the result.
          r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state == RUN);
  assign out_valid = (r_state == DONE);
  assign p         = r_acc;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench: table-driven WIDTH=8 products, multi-cycle corner sequences,
// and an exhaustive WIDTH=4 sweep with random consumer stalls.
module tb_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  a_in = '0;
  logic [7:0]  b_in = '0;
  logic        in_ready;
  logic        out_valid;
  logic        busy;
  logic [15:0] p;

  logic        in_valid4 = 1'b0;
  logic        out_ready4 = 1'b0;
  logic [3:0]  a4 = '0;
  logic [3:0]  b4 = '0;
  logic        in_ready4;
  logic        out_valid4;
  logic        busy4;
  logic [7:0]  p4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mul_seq_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_in),
    .b         (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  mul_seq_ctrl #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .a         (a4),
    .b         (b4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .p         (p4),
    .busy      (busy4)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    int          stall;
    logic [15:0] exp_p;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction on the WIDTH=8 instance, checking latency, stability and handoff.
  task automatic run_w8(input logic [7:0] va, input logic [7:0] vb, input int stall,
                        input logic [15:0] exp_p);
    int k;
    int early;
    k = 0;
    while (!in_ready && k < 50) begin
      tick();
      k++;
    end
    check("in_ready before accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a_in = va;
    b_in = vb;
    tick();
    in_valid = 1'b0;
    check("busy after accept", 32'(busy), 32'd1);
    early = 0;
    for (int c = 1; c < 16; c++) begin
      tick();
      if (out_valid) early++;
    end
    check("out_valid before latency", 32'(early), 32'd0);
    tick();
    check("out_valid at latency 16", 32'(out_valid), 32'd1);
    check("product", 32'(p), 32'(exp_p));
    for (int s = 0; s < stall; s++) begin
      tick();
      check("out_valid held under stall", 32'(out_valid), 32'd1);
      check("p stable under stall", 32'(p), 32'(exp_p));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("out_valid after handoff", 32'(out_valid), 32'd0);
    check("in_ready after handoff", 32'(in_ready), 32'd1);
    $display("w8 a=%0d b=%0d stall=%0d p=%0d exp=%0d", va, vb, stall, p, exp_p);
  endtask

  initial begin
    int k;
    int cnt;
    logic r;

    vecs[0] = '{8'd255, 8'd255, 0, 16'hFE01};
    vecs[1] = '{8'd0,   8'd200, 0, 16'd0};
    vecs[2] = '{8'd13,  8'd11,  0, 16'd143};
    vecs[3] = '{8'd1,   8'd255, 0, 16'd255};
    vecs[4] = '{8'd100, 8'd3,   5, 16'd300};
    vecs[5] = '{8'd170, 8'd85,  1, 16'd14450};
    vecs[6] = '{8'd15,  8'd240, 0, 16'd3600};
    vecs[7] = '{8'd128, 8'd2,   2, 16'd256};

    rst_n = 1'b0;
    tick();
    tick();
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset p", 32'(p), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 8; v++) begin
      run_w8(vecs[v].a, vecs[v].b, vecs[v].stall, vecs[v].exp_p);
    end

    // Operand isolation and no same-cycle turnaround at the handoff edge.
    in_valid = 1'b1;
    a_in = 8'd7;
    b_in = 8'd9;
    tick();
    a_in = 8'd255;
    b_in = 8'd255;
    cnt = 0;
    for (int c = 1; c < 16; c++) begin
      if (!busy) cnt++;
      tick();
    end
    check("isolation busy throughout RUN", 32'(cnt), 32'd0);
    tick();
    check("isolation out_valid", 32'(out_valid), 32'd1);
    check("isolation product", 32'(p), 32'd63);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("no turnaround in_ready", 32'(in_ready), 32'd1);
    check("no turnaround busy", 32'(busy), 32'd0);
    tick();
    in_valid = 1'b0;
    check("re-accept busy", 32'(busy), 32'd1);
    for (int c = 0; c < 16; c++) tick();
    check("re-accept product", 32'(p), 32'hFE01);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    $display("isolation sequence done p-last=0x%0h", p);

    // Reset mid-RUN discards the product.
    in_valid = 1'b1;
    a_in = 8'd50;
    b_in = 8'd50;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    rst_n = 1'b0;
    tick();
    check("midrun reset in_ready", 32'(in_ready), 32'd1);
    check("midrun reset out_valid", 32'(out_valid), 32'd0);
    check("midrun reset p", 32'(p), 32'd0);
    check("midrun reset busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (out_valid || busy) cnt++;
    end
    check("no pulse after reset", 32'(cnt), 32'd0);
    run_w8(8'd2, 8'd3, 0, 16'd6);

    // Exhaustive WIDTH=4 sweep with random stalls.
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        in_valid4 = 1'b1;
        a4 = 4'(ai);
        b4 = 4'(bi);
        k = 0;
        while (!in_ready4 && k < 20) begin
          tick();
          k++;
        end
        tick();
        in_valid4 = 1'b0;
        k = 0;
        while (!out_valid4 && k < 20) begin
          tick();
          k++;
        end
        check("w4 latency", 32'(k), 32'd4);
        check("w4 product", 32'(p4), 32'(ai * bi));
        k = 0;
        do begin
          r = (k >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
          out_ready4 = r;
          tick();
          k++;
          if (!r) check("w4 p stable", 32'(p4), 32'(ai * bi));
        end while (!r);
        out_ready4 = 1'b0;
        check("w4 handoff", 32'(out_valid4), 32'd0);
        $display("w4 a=%0d b=%0d p=%0d exp=%0d stalls=%0d", ai, bi, p4, ai * bi, k - 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
